// File: rtl/pov_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pov_pkg
// Description : Shared widths, null character and arbiter state encoding for
//               the POV transmit path (arbiter, loader, transmitter).
// Revision    : 1.0 - initial release
// ============================================================================
package pov_pkg;

    localparam int NUM_CHARS = 11;
    localparam int CHAR_W    = 7;
    localparam int STR_W     = NUM_CHARS * CHAR_W;

    localparam logic [CHAR_W-1:0] NULL_CHAR = 7'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_SEND  = 2'd2,
        ST_DONE  = 2'd3
    } arb_state_e;

endpackage
`default_nettype wire

// File: rtl/pov_tx_arbiter_rr_pick2.sv
`default_nettype none
// ============================================================================
// Module      : rr_pick2
// Description : Combinational two-way round-robin picker. The requester
//               pointed to by prio wins a tie; a lone requester always wins.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_pick2 (
    input  logic [1:0] req_i,
    input  logic       prio_i,
    output logic       winner_o,
    output logic       valid_o
);

    // Any request at all makes the pick valid.
    assign valid_o  = |req_i;

    // Favoured index keeps the grant if it is requesting, else the other one.
    assign winner_o = req_i[prio_i] ? prio_i : ~prio_i;

endmodule
`default_nettype wire

// File: rtl/pov_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pov_tx_arbiter
// Description : Round-robin arbiter sharing the POV serial transmitter between
//               two string sources. Latches the winning string, strobes
//               Complete, holds ownership for TX_CYCLES and then acks.
// Revision    : 1.0 - initial release
// ============================================================================
module pov_tx_arbiter #(
    parameter int NUM_CHARS = pov_pkg::NUM_CHARS,
    parameter int CHAR_W    = pov_pkg::CHAR_W,
    parameter int TX_CYCLES = 5500
) (
    input  logic                          clk,
    input  logic                          Reset,
    input  logic [1:0]                    Req,
    input  logic [NUM_CHARS*CHAR_W-1:0]   String0,
    input  logic [NUM_CHARS*CHAR_W-1:0]   String1,
    output logic [1:0]                    Ack,
    output logic                          Owner,
    output logic                          Busy,
    output logic [NUM_CHARS*CHAR_W-1:0]   StringPOV,
    output logic                          Complete
);
    import pov_pkg::*;

    localparam int              STR_BITS = NUM_CHARS * CHAR_W;
    localparam int              CNT_W    = $clog2(TX_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TX_CYCLES - 1);

    arb_state_e          state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [STR_BITS-1:0] str_q;
    logic                owner_q;
    logic                prio_q;
    logic                complete_q;
    logic [1:0]          ack_q;

    logic                pick_winner_d;
    logic                pick_valid_d;
    logic [STR_BITS-1:0] pick_str_d;
    logic                pick_null_d;

    rr_pick2 u_pick (
        .req_i    (Req),
        .prio_i   (prio_q),
        .winner_o (pick_winner_d),
        .valid_o  (pick_valid_d)
    );

    // Candidate string of the current winner and whether it is all null chars.
    always_comb begin
        pick_str_d  = pick_winner_d ? String1 : String0;
        pick_null_d = 1'b1;
        for (int i = 0; i < NUM_CHARS; i++) begin
            if (pick_str_d[i*CHAR_W +: CHAR_W] != CHAR_W'(NULL_CHAR)) begin
                pick_null_d = 1'b0;
            end
        end
    end

    // Arbiter FSM with transmit-window counter and registered outputs.
    always_ff @(posedge clk) begin
        if (Reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            str_q      <= '0;
            owner_q    <= 1'b0;
            prio_q     <= 1'b0;
            complete_q <= 1'b0;
            ack_q      <= 2'b00;
        end else begin
            complete_q <= 1'b0;
            ack_q      <= 2'b00;
            case (state_q)
                ST_IDLE: begin
                    if (pick_valid_d) begin
                        str_q   <= pick_str_d;
                        owner_q <= pick_winner_d;
                        if (pick_null_d) begin
                            // Nothing to send: acknowledge straight away.
                            state_q                <= ST_DONE;
                            ack_q[pick_winner_d]   <= 1'b1;
                        end else begin
                            state_q    <= ST_START;
                            complete_q <= 1'b1;
                        end
                    end
                end
                ST_START: begin
                    cnt_q   <= '0;
                    state_q <= ST_SEND;
                end
                ST_SEND: begin
                    if (cnt_q == CNT_LAST) begin
                        state_q        <= ST_DONE;
                        ack_q[owner_q] <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_DONE: begin
                    prio_q  <= ~owner_q;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign Ack       = ack_q;
    assign Owner     = owner_q;
    assign Busy      = (state_q != ST_IDLE);
    assign StringPOV = str_q;
    assign Complete  = complete_q;

endmodule
`default_nettype wire

// File: tb/tb_pov_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pov_tx_arbiter
// Description : Randomized bench for pov_tx_arbiter. A timeline model records,
//               per grant, the cycles at which Complete and Ack must appear
//               and derives all expected outputs from those cycle numbers.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pov_tx_arbiter;

    localparam int TX        = 8;
    localparam int STR_W     = 77;
    localparam int N_CYCLES  = 4000;

    logic             clk = 1'b0;
    logic             Reset;
    logic [1:0]       Req;
    logic [STR_W-1:0] String0;
    logic [STR_W-1:0] String1;
    logic [1:0]       Ack;
    logic             Owner;
    logic             Busy;
    logic [STR_W-1:0] StringPOV;
    logic             Complete;

    pov_tx_arbiter #(.TX_CYCLES(TX)) dut (
        .clk       (clk),
        .Reset     (Reset),
        .Req       (Req),
        .String0   (String0),
        .String1   (String1),
        .Ack       (Ack),
        .Owner     (Owner),
        .Busy      (Busy),
        .StringPOV (StringPOV),
        .Complete  (Complete)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Timeline model: cycle numbers of the last grant and its events.
    int               g_cyc;
    int               c_cyc;
    int               a_cyc;
    int               free_cyc;
    logic [STR_W-1:0] m_str;
    logic             m_owner;
    logic             m_prio;

    int n_grants = 0;
    int n_nulls  = 0;
    int n_resets = 0;

    task automatic check_val(input string tag, input logic [STR_W-1:0] act,
                             input logic [STR_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, act, exp);
        end
    endtask

    task automatic model_reset(input int first_idle);
        g_cyc    = -100;
        c_cyc    = -100;
        a_cyc    = -100;
        free_cyc = first_idle;
        m_str    = '0;
        m_owner  = 1'b0;
        m_prio   = 1'b0;
    endtask

    task automatic check_outputs(input int n);
        logic [1:0] exp_ack;
        exp_ack = (n == a_cyc) ? (m_owner ? 2'b10 : 2'b01) : 2'b00;
        check_val("Complete",  STR_W'(Complete),  STR_W'(n == c_cyc));
        check_val("Ack",       STR_W'(Ack),       STR_W'(exp_ack));
        check_val("Busy",      STR_W'(Busy),      STR_W'(n > g_cyc && n <= a_cyc));
        check_val("Owner",     STR_W'(Owner),     STR_W'(m_owner));
        check_val("StringPOV", StringPOV,         m_str);
    endtask

    function automatic logic [STR_W-1:0] new_string();
        logic [95:0] raw;
        raw = {$urandom, $urandom, $urandom};
        if ($urandom_range(0, 5) == 0) return '0;
        return raw[STR_W-1:0];
    endfunction

    // Requesters hold Req until acked, usually drop it in the Ack cycle,
    // and raise new requests at random with a fresh string.
    task automatic drive_inputs(input int n);
        logic dropped;
        Reset = ($urandom_range(0, 199) == 0);
        for (int r = 0; r < 2; r++) begin
            dropped = 1'b0;
            if (n == a_cyc && int'(m_owner) == r && Req[r] && $urandom_range(0, 3) != 0) begin
                Req[r]  = 1'b0;
                dropped = 1'b1;
            end
            if (!Req[r] && !dropped && $urandom_range(0, 3) == 0) begin
                if (r == 0) String0 = new_string();
                else        String1 = new_string();
                Req[r] = 1'b1;
            end
        end
    endtask

    // Apply what the arbiter does with the inputs sampled at the end of cycle n.
    task automatic model_update(input int n);
        logic             w;
        logic [STR_W-1:0] s;
        if (Reset) begin
            n_resets++;
            model_reset(n + 1);
        end else if (n >= free_cyc && Req != 2'b00) begin
            w = (Req == 2'b11) ? m_prio : Req[1];
            s = w ? String1 : String0;
            g_cyc   = n;
            m_str   = s;
            m_owner = w;
            m_prio  = ~w;
            n_grants++;
            if (s == '0) begin
                n_nulls++;
                c_cyc = -100;
                a_cyc = n + 1;
            end else begin
                c_cyc = n + 1;
                a_cyc = n + TX + 2;
            end
            free_cyc = a_cyc + 1;
        end
    endtask

    initial begin
        Reset   = 1'b1;
        Req     = 2'b00;
        String0 = '0;
        String1 = '0;
        model_reset(0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        cyc = 0;
        for (int i = 0; i < N_CYCLES; i++) begin
            check_outputs(cyc);
            drive_inputs(cyc);
            model_update(cyc);
            @(negedge clk);
            cyc++;
        end
        $display("grants=%0d nulls=%0d resets=%0d", n_grants, n_nulls, n_resets);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
